// File: rtl/ipcu_core.sv
// Input-port control unit: tracks buffer occupancy, strobes writes, requests
// the output arbiter while data is buffered and returns one credit per read.
//
// state | meaning
// IDLE  | buffer empty, no request
// REQ   | data buffered, request held until arb_ack
// READ  | one-cycle read of the head slot
module ipcu_core #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_ack,
    input  logic pipe_en,
    output logic wr_strobe,
    output logic rd_strobe,
    output logic rqs_strobe,
    output logic crt_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] READ = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] occ_nxt;
    logic             acc;
    logic             rd;

    // Full check uses registered occ, so a read in the same cycle frees no slot yet.
    assign acc = pipe_en & (occ != CNT_W'(DEPTH));
    assign rd  = (state == READ);

    always_comb begin
        occ_nxt = occ;
        if (acc && !rd)
            occ_nxt = occ + CNT_W'(1);
        else if (!acc && rd)
            occ_nxt = occ - CNT_W'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (occ != '0) state_nxt = REQ;
            REQ:     if (arb_ack) state_nxt = READ;
            READ:    state_nxt = (occ_nxt != '0) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            occ       <= '0;
            wr_strobe <= 1'b0;
            crt_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            occ       <= occ_nxt;
            wr_strobe <= acc;
            crt_out   <= rd_strobe;
        end
    end

    assign rqs_strobe = (state == REQ);
    assign rd_strobe  = (state == READ);

endmodule

// File: tb/tb_ipcu_core.sv
// Directed bench for ipcu_core: each step pushes the expected output vector
// {wr,rd,rqs,crt} for the coming cycle and pops/compares it after the edge.
module tb_ipcu_core;

    logic clk = 1'b0;
    logic rst;
    logic arb_ack;
    logic pipe_en;
    logic wr_strobe;
    logic rd_strobe;
    logic rqs_strobe;
    logic crt_out;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [3:0] outs;
    } exp_t;

    exp_t sb[$];

    ipcu_core #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .arb_ack    (arb_ack),
        .pipe_en    (pipe_en),
        .wr_strobe  (wr_strobe),
        .rd_strobe  (rd_strobe),
        .rqs_strobe (rqs_strobe),
        .crt_out    (crt_out)
    );

    always #5 clk = ~clk;

    // Drive inputs for the next edge, then check the cycle that follows it.
    task automatic step(input string tag, input logic r, input logic p,
                        input logic a, input logic [3:0] exp_outs);
        exp_t e;
        logic [3:0] obs;
        rst     = r;
        pipe_en = p;
        arb_ack = a;
        e.tag   = tag;
        e.outs  = exp_outs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {wr_strobe, rd_strobe, rqs_strobe, crt_out};
        vectors++;
        assert (obs === e.outs) else begin
            miscompares++;
            $error("FAIL %s observed wr/rd/rqs/crt=%b expected=%b", e.tag, obs, e.outs);
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; pipe_en = 1'b0; arb_ack = 1'b0;
        @(posedge clk);
        #2;

        // reset and idle
        step("rst_0",  1, 0, 0, 4'b0000);
        step("rst_1",  1, 0, 0, 4'b0000);
        step("idle_0", 0, 0, 0, 4'b0000);
        step("idle_1", 0, 0, 1, 4'b0000);
        step("idle_2", 0, 0, 0, 4'b0000);

        // single flit: write, request, grant, credit
        step("one_wr",   0, 1, 0, 4'b1000);
        step("one_rq2",  0, 0, 0, 4'b0010);
        step("one_rq3",  0, 0, 0, 4'b0010);
        step("one_rd",   0, 0, 1, 4'b0100);
        step("one_crt",  0, 0, 0, 4'b0001);
        step("one_end0", 0, 0, 0, 4'b0000);
        step("one_end1", 0, 0, 0, 4'b0000);

        // fill to DEPTH, extra writes blocked
        step("fill_rst", 1, 0, 0, 4'b0000);
        step("fill_1",   0, 1, 0, 4'b1000);
        step("fill_2",   0, 1, 0, 4'b1010);
        step("fill_3",   0, 1, 0, 4'b1010);
        step("fill_4",   0, 1, 0, 4'b1010);
        step("fill_5",   0, 1, 0, 4'b0010);
        step("fill_6",   0, 1, 0, 4'b0010);
        step("fill_7",   0, 0, 0, 4'b0010);

        // full during READ: write blocked that edge, accepted the next
        step("full_rd",   0, 0, 1, 4'b0100);
        step("full_blk",  0, 1, 0, 4'b0011);
        step("full_wr",   0, 1, 0, 4'b1010);
        step("full_again",0, 1, 0, 4'b0010);
        step("full_hold", 0, 0, 0, 4'b0010);

        // drain three flits with grant held
        step("drn_rst", 1, 0, 0, 4'b0000);
        step("drn_w1",  0, 1, 0, 4'b1000);
        step("drn_w2",  0, 1, 0, 4'b1010);
        step("drn_w3",  0, 1, 0, 4'b1010);
        step("drn_r1",  0, 0, 1, 4'b0100);
        step("drn_c1",  0, 0, 1, 4'b0011);
        step("drn_r2",  0, 0, 1, 4'b0100);
        step("drn_c2",  0, 0, 1, 4'b0011);
        step("drn_r3",  0, 0, 1, 4'b0100);
        step("drn_c3",  0, 0, 1, 4'b0001);
        step("drn_id0", 0, 0, 1, 4'b0000);
        step("drn_id1", 0, 0, 0, 4'b0000);

        // reset while requesting with two flits buffered
        step("mid_w1",  0, 1, 0, 4'b1000);
        step("mid_w2",  0, 1, 0, 4'b1010);
        step("mid_rst", 1, 0, 0, 4'b0000);
        step("mid_id0", 0, 0, 1, 4'b0000);
        step("mid_id1", 0, 0, 0, 4'b0000);
        step("mid_id2", 0, 0, 0, 4'b0000);
        step("mid_new", 0, 1, 0, 4'b1000);
        step("mid_rq",  0, 0, 0, 4'b0010);

        // reset during READ drops the pending credit
        step("rdr_rd",  0, 0, 1, 4'b0100);
        step("rdr_rst", 1, 0, 0, 4'b0000);
        step("rdr_id0", 0, 0, 0, 4'b0000);
        step("rdr_id1", 0, 0, 0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
